execute_lsu_split: RTL and testbench

//  Parametrised load/store unit for the execute stage: computes base+sext(imm), splits misaligned accesses across two memory words.

---
 rtl/execute_lsu_split.sv | 208 ++++++++++++++++++++
 tb/tb_execute_lsu_split.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_lsu_split.sv
// Load/store unit: EA = base+sext(imm), misaligned accesses split over two words; stores busy 2-3 cycles, loads answer at 2+RD_LAT (3+RD_LAT split).
// One request in flight: req_ready drops while busy, and a held-off response (rsp_ready low) keeps the unit in RESP.
module execute_lsu_split #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int IMM_W  = 32,
    parameter int TAG_W  = 4,
    parameter int RD_LAT = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic [2:0]                            req_op,
    input  logic                                  req_signed,
    input  logic [ADDR_W-1:0]                     req_base,
    input  logic [IMM_W-1:0]                      req_imm,
    input  logic [DATA_W-1:0]                     req_st_data,
    input  logic [TAG_W-1:0]                      req_tag,
    output logic [ADDR_W-$clog2(DATA_W/8)-1:0]    mem_addr,
    output logic                                  mem_re,
    output logic [DATA_W/8-1:0]                   mem_we,
    output logic [DATA_W-1:0]                     mem_wdata,
    input  logic [DATA_W-1:0]                     mem_rdata,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [DATA_W-1:0]                     rsp_data,
    output logic [TAG_W-1:0]                      rsp_tag,
    output logic                                  busy
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int WA_W  = ADDR_W - OFF_W;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE0 = 3'd1;
    localparam logic [2:0] S_ISSUE1 = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              is_load_q, is_load_d;
    logic              signed_q, signed_d;
    logic [3:0]        n_q, n_d;
    logic              split_q, split_d;
    logic [WA_W-1:0]   word0_q, word0_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [DATA_W-1:0] st_data_q, st_data_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [RD_LAT-1:0] pend_q, pend_d;
    logic [RD_LAT-1:0] pend_w1_q, pend_w1_d;

    logic [ADDR_W-1:0] req_ea;
    logic [OFF_W-1:0]  req_off;
    logic [3:0]        req_n;
    logic              req_split;

    assign req_ea    = req_base + ADDR_W'($signed(req_imm));
    assign req_off   = req_ea[OFF_W-1:0];
    assign req_split = (int'(req_off) + int'(req_n)) > BYTES;

    always_comb begin
        case (req_op)
            3'd0, 3'd3: req_n = 4'd1;
            3'd1, 3'd4: req_n = 4'd4;
            3'd2, 3'd5: req_n = 4'd8;
            default:    req_n = 4'd0;
        endcase
    end

    // Both words' lanes come from one double-width shift: low half is word0, high half word1.
    logic [2*BYTES-1:0]  lane_mask, we_wide;
    logic [2*DATA_W-1:0] wd_wide;
    logic [WA_W-1:0]     word1;

    always_comb begin
        case (n_q)
            4'd1:    lane_mask = (2*BYTES)'(8'h01);
            4'd4:    lane_mask = (2*BYTES)'(8'h0F);
            4'd8:    lane_mask = (2*BYTES)'(8'hFF);
            default: lane_mask = '0;
        endcase
    end

    assign we_wide = lane_mask << off_q;
    assign wd_wide = {{DATA_W{1'b0}}, st_data_q} << {off_q, 3'b000};
    assign word1   = word0_q + WA_W'(1);

    logic [DATA_W-1:0] ld_raw, ld_ext;
    assign ld_raw = DATA_W'({hi_q, lo_q} >> {off_q, 3'b000});

    always_comb begin
        case (n_q)
            4'd1:    ld_ext = signed_q ? DATA_W'($signed(ld_raw[7:0]))  : DATA_W'(ld_raw[7:0]);
            4'd4:    ld_ext = signed_q ? DATA_W'($signed(ld_raw[31:0])) : DATA_W'(ld_raw[31:0]);
            4'd8:    ld_ext = signed_q ? DATA_W'($signed(ld_raw[63:0])) : DATA_W'(ld_raw[63:0]);
            default: ld_ext = '0;
        endcase
    end

    logic issue, issue_w1;
    assign issue    = (state_q == S_ISSUE0) || (state_q == S_ISSUE1);
    assign issue_w1 = (state_q == S_ISSUE1);

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE);
    assign mem_addr  = issue ? (issue_w1 ? word1 : word0_q) : '0;
    assign mem_re    = issue && is_load_q;
    assign mem_we    = (issue && !is_load_q) ?
                       (issue_w1 ? we_wide[2*BYTES-1:BYTES] : we_wide[BYTES-1:0]) : '0;
    assign mem_wdata = (issue && !is_load_q) ?
                       (issue_w1 ? wd_wide[2*DATA_W-1:DATA_W] : wd_wide[DATA_W-1:0]) : '0;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_valid ? ld_ext : '0;
    assign rsp_tag   = rsp_valid ? tag_q : '0;

    always_comb begin
        state_d   = state_q;
        is_load_d = is_load_q;
        signed_d  = signed_q;
        n_d       = n_q;
        split_d   = split_q;
        word0_d   = word0_q;
        off_d     = off_q;
        st_data_d = st_data_q;
        tag_d     = tag_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        pend_d    = pend_q << 1;
        pend_w1_d = pend_w1_q << 1;

        // The last pipe stage marks the cycle mem_rdata belongs to an issued read.
        if (pend_q[RD_LAT-1]) begin
            if (pend_w1_q[RD_LAT-1]) hi_d = mem_rdata;
            else                     lo_d = mem_rdata;
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    is_load_d = (req_op < 3'd3);
                    signed_d  = req_signed;
                    n_d       = req_n;
                    split_d   = req_split;
                    word0_d   = req_ea[ADDR_W-1:OFF_W];
                    off_d     = req_off;
                    st_data_d = req_st_data;
                    tag_d     = req_tag;
                    state_d   = (req_n == 4'd0) ? S_IDLE : S_ISSUE0;
                end
            end
            S_ISSUE0: begin
                if (is_load_q) pend_d[0] = 1'b1;
                if (split_q)        state_d = S_ISSUE1;
                else if (is_load_q) state_d = S_WAIT;
                else                state_d = S_IDLE;
            end
            S_ISSUE1: begin
                if (is_load_q) begin
                    pend_d[0]    = 1'b1;
                    pend_w1_d[0] = 1'b1;
                end
                state_d = is_load_q ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (pend_d == '0) state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            is_load_q <= 1'b0;
            signed_q  <= 1'b0;
            n_q       <= '0;
            split_q   <= 1'b0;
            word0_q   <= '0;
            off_q     <= '0;
            st_data_q <= '0;
            tag_q     <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            pend_q    <= '0;
            pend_w1_q <= '0;
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
            signed_q  <= signed_d;
            n_q       <= n_d;
            split_q   <= split_d;
            word0_q   <= word0_d;
            off_q     <= off_d;
            st_data_q <= st_data_d;
            tag_q     <= tag_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            pend_q    <= pend_d;
            pend_w1_q <= pend_w1_d;
        end
    end
endmodule

// File: tb/tb_execute_lsu_split.sv
// Scoreboarded bench for execute_lsu_split with RD_LAT=2 and a behavioural read-only memory.
module tb_execute_lsu_split;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic        req_signed;
    logic [31:0] req_base, req_imm;
    logic [63:0] req_st_data;
    logic [3:0]  req_tag;
    logic [28:0] mem_addr;
    logic        mem_re;
    logic [7:0]  mem_we;
    logic [63:0] mem_wdata, mem_rdata;
    logic        rsp_valid, rsp_ready;
    logic [63:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic        busy;

    execute_lsu_split #(.ADDR_W(32), .DATA_W(64), .IMM_W(32), .TAG_W(4), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_signed(req_signed), .req_base(req_base), .req_imm(req_imm), .req_st_data(req_st_data),
        .req_tag(req_tag), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Memory: preloaded once, read data returned RD_LAT cycles after mem_re, garbage otherwise.
    logic [63:0] mem [logic [28:0]];
    logic [63:0] rd_s0, rd_s1;

    function automatic logic [63:0] rd_word(logic [28:0] a);
        return mem.exists(a) ? mem[a] : 64'h0;
    endfunction

    always @(posedge clk) begin
        rd_s0 <= mem_re ? rd_word(mem_addr) : 64'hDEADBEEFDEADBEEF;
        rd_s1 <= rd_s0;
    end
    assign mem_rdata = rd_s1;

    typedef struct packed {
        logic [28:0] addr;
        logic        re;
        logic [7:0]  we;
        logic [63:0] wd;
    } mem_ev_t;
    typedef struct packed {
        logic [63:0] d;
        logic [3:0]  tag;
    } rsp_ev_t;

    mem_ev_t mem_q[$];
    rsp_ev_t rsp_q[$];

    function automatic logic [63:0] lanes(logic [7:0] we);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = {8{we[b]}};
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_re || (mem_we != 8'h0)) begin
                if (mem_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mem_unexpected addr=%h re=%0d we=%h required=no access", mem_addr, mem_re, mem_we);
                end else begin
                    mem_ev_t e;
                    e = mem_q.pop_front();
                    chk("mem_addr", 64'(mem_addr), 64'(e.addr));
                    chk("mem_re", 64'(mem_re), 64'(e.re));
                    chk("mem_we", 64'(mem_we), 64'(e.we));
                    chk("mem_wdata", mem_wdata & lanes(mem_we), e.wd & lanes(e.we));
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected data=%h tag=%h required=no response", rsp_data, rsp_tag);
                end else begin
                    rsp_ev_t r;
                    r = rsp_q.pop_front();
                    chk("rsp_data", rsp_data, r.d);
                    chk("rsp_tag", 64'(rsp_tag), 64'(r.tag));
                end
            end
        end
    end

    task automatic exp_mem(logic [28:0] a, logic re, logic [7:0] we, logic [63:0] wd);
        mem_ev_t e;
        e.addr = a; e.re = re; e.we = we; e.wd = wd;
        mem_q.push_back(e);
    endtask

    task automatic exp_rsp(logic [63:0] d, logic [3:0] tag);
        rsp_ev_t r;
        r.d = d; r.tag = tag;
        rsp_q.push_back(r);
    endtask

    // Called just after a posedge; returns just after the accepting posedge (cycle 1).
    task automatic send(logic [2:0] op, logic sg, logic [31:0] base, logic [31:0] imm,
                        logic [63:0] d, logic [3:0] tag);
        logic ok;
        req_op = op; req_signed = sg; req_base = base; req_imm = imm;
        req_st_data = d; req_tag = tag; req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("accept", 64'(ok), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Issues a load with its expected reads/response queued; returns at the negedge of the first rsp_valid cycle.
    task automatic do_load(string name, logic [2:0] op, logic sg, logic [31:0] base, logic [31:0] imm,
                           logic [3:0] tag, logic [28:0] w0, logic split, logic [63:0] d, int lat_exp);
        int lat;
        exp_mem(w0, 1'b1, 8'h00, 64'h0);
        if (split) exp_mem(w0 + 29'd1, 1'b1, 8'h00, 64'h0);
        exp_rsp(d, tag);
        send(op, sg, base, imm, 64'h0, tag);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        chk({name, "_latency"}, 64'(lat), 64'(lat_exp));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=stuck required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_signed = 1'b0; req_base = '0;
        req_imm = '0; req_st_data = '0; req_tag = '0; rsp_ready = 1'b1;
        mem[29'h20]       = 64'h8877665544332211;
        mem[29'h21]       = 64'h0000000000CCBBAA;
        mem[29'h30]       = 64'h1234567880000000;
        mem[29'h3F]       = 64'h5555555555555555;
        mem[29'h40]       = 64'h6666666666666666;
        mem[29'h1FFFFFFF] = 64'h0102030405060708;
        mem[29'h0]        = 64'h1112131415161718;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_re", 64'(mem_re), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;

        // Aligned SQ
        exp_mem(29'h21, 1'b0, 8'hFF, 64'h1122334455667788);
        send(3'd5, 1'b0, 32'h100, 32'h8, 64'h1122334455667788, 4'd0);
        @(negedge clk); chk("sq_ready_c1", 64'(req_ready), 64'd0);
        @(negedge clk); chk("sq_ready_c2", 64'(req_ready), 64'd1);
        @(posedge clk); #1;

        // Split SD
        exp_mem(29'h20, 1'b0, 8'hC0, 64'hCCDD000000000000);
        exp_mem(29'h21, 1'b0, 8'h03, 64'h000000000000AABB);
        send(3'd4, 1'b0, 32'h106, 32'h0, 64'h00000000AABBCCDD, 4'd0);
        @(negedge clk); chk("sd_ready_c1", 64'(req_ready), 64'd0);
        @(negedge clk); chk("sd_ready_c2", 64'(req_ready), 64'd0);
        @(negedge clk); chk("sd_ready_c3", 64'(req_ready), 64'd1);
        @(posedge clk); #1;

        do_load("lq_split", 3'd2, 1'b0, 32'h100, 32'h5, 4'd3, 29'h20, 1'b1, 64'h0000CCBBAA887766, 3 + RD_LAT);
        @(posedge clk); #1;
        do_load("lb_signed", 3'd0, 1'b1, 32'h10F, 32'hFFFFFFF8, 4'd1, 29'h20, 1'b0, 64'hFFFFFFFFFFFFFF88, 2 + RD_LAT);
        @(posedge clk); #1;
        do_load("lb_unsigned", 3'd0, 1'b0, 32'h107, 32'h0, 4'd2, 29'h20, 1'b0, 64'h0000000000000088, 2 + RD_LAT);
        @(posedge clk); #1;
        do_load("ld_signed", 3'd1, 1'b1, 32'h180, 32'h0, 4'd5, 29'h30, 1'b0, 64'hFFFFFFFF80000000, 2 + RD_LAT);
        @(posedge clk); #1;

        // Response held off for three cycles
        rsp_ready = 1'b0;
        do_load("ld_stall", 3'd1, 1'b0, 32'h184, 32'h0, 4'd7, 29'h30, 1'b0, 64'h0000000012345678, 2 + RD_LAT);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("stall_rsp_data", rsp_data, 64'h0000000012345678);
            chk("stall_rsp_tag", 64'(rsp_tag), 64'd7);
            chk("stall_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_hs_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("post_hs_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;

        // Split LQ wrapping past the top of the address space
        do_load("lq_wrap", 3'd2, 1'b0, 32'hFFFFFFF0, 32'hD, 4'd2, 29'h1FFFFFFF, 1'b1, 64'h1415161718010203, 3 + RD_LAT);
        @(posedge clk); #1;

        // Reserved op: no access, no response, idle immediately
        send(3'd6, 1'b0, 32'h100, 32'h0, 64'h0, 4'd9);
        @(negedge clk);
        chk("rsvd_busy", 64'(busy), 64'd0);
        chk("rsvd_req_ready", 64'(req_ready), 64'd1);
        repeat (4) @(posedge clk);
        #1;

        // Reset while a split load waits for data
        exp_mem(29'h3F, 1'b1, 8'h00, 64'h0);
        exp_mem(29'h40, 1'b1, 8'h00, 64'h0);
        send(3'd2, 1'b0, 32'h1FD, 32'h0, 64'h0, 4'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("abort_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        do_load("lq_after_rst", 3'd2, 1'b0, 32'h105, 32'h0, 4'd6, 29'h20, 1'b1, 64'h0000CCBBAA887766, 3 + RD_LAT);
        repeat (6) @(posedge clk);
        @(negedge clk);

        chk("mem_queue_drained", 64'(mem_q.size()), 64'd0);
        chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
